sprite_dma: RTL

Sprite attribute DMA for the Comet sprite engine. Copies a block of packed 4-byte sprite records from CPU memory into sprite RAM through a request/acknowledge memory port, or zero-fills sprite RAM to disable all sprites. Sits between the CPU bus and the sprite RAM write port; the sprite engine only reads that RAM. Transfers can be restricted to vblank so the engine never sees a half-updated table mid-frame.

---
 rtl/sprite_dma_if.sv | 21 ++
 rtl/sprite_dma.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sprite_dma_if.sv
// Source-memory read port and sprite RAM write port of the sprite attribute DMA.
// The master side is the DMA engine; the slave side is memory plus sprite RAM.
interface sprite_dma_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic [6:0]  spriteram_addr;
    logic [7:0]  spriteram_data_in;
    logic        spriteram_wr;

    modport master (
        output mem_req, mem_addr, spriteram_addr, spriteram_data_in, spriteram_wr,
        input  mem_ack, mem_data
    );

    modport slave (
        input  mem_req, mem_addr, spriteram_addr, spriteram_data_in, spriteram_wr,
        output mem_ack, mem_data
    );
endinterface

// File: rtl/sprite_dma.sv
// Sprite attribute DMA: copies packed sprite records from CPU memory into sprite RAM
// one byte at a time, or zero-fills it, optionally only while vblank is high.
module sprite_dma #(
    parameter int SPR_MAX   = 32,
    parameter int REC_BYTES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         vblank,
    input  logic         cpu_wr,
    input  logic [1:0]   cpu_addr,
    input  logic [7:0]   cpu_din,
    output logic [7:0]   cpu_dout,
    sprite_dma_if.master bus,
    output logic         busy,
    output logic         done
);
    localparam int IDX_W = $clog2(SPR_MAX * REC_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VB,
        S_REQ,
        S_WRITE,
        S_FINISH
    } state_t;

    localparam logic [1:0] REG_SRC_LO = 2'd0;
    localparam logic [1:0] REG_SRC_HI = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    state_t           state;
    logic [15:0]      src;
    logic [4:0]       count;
    logic             clear_mode;
    logic             vblank_only;
    logic             done_sticky;
    logic [IDX_W-1:0] index;
    logic [IDX_W-1:0] last_index;
    logic             ctrl_wr;
    logic             reg_wr_ok;

    // src/count only change in IDLE, so they double as the latched transfer setup.
    assign last_index = IDX_W'((int'(count) + 1) * REC_BYTES - 1);
    assign ctrl_wr    = cpu_wr && (cpu_addr == REG_CTRL);
    assign reg_wr_ok  = cpu_wr && (state == S_IDLE);

    always_comb begin
        case (cpu_addr)
            REG_SRC_LO: cpu_dout = src[7:0];
            REG_SRC_HI: cpu_dout = src[15:8];
            REG_CTRL:   cpu_dout = {busy, done_sticky, 3'b000, vblank_only, clear_mode, 1'b0};
            default:    cpu_dout = {3'b000, count};
        endcase
    end

    // NOTE: reset is sampled on the clock edge (synchronous, active-low); it is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state                 <= S_IDLE;
            src                   <= 16'h0000;
            count                 <= 5'd31;
            clear_mode            <= 1'b0;
            vblank_only           <= 1'b0;
            done_sticky           <= 1'b0;
            index                 <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            bus.mem_req           <= 1'b0;
            bus.mem_addr          <= 16'h0000;
            bus.spriteram_addr    <= '0;
            bus.spriteram_data_in <= 8'h00;
            bus.spriteram_wr      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only here; the later assignment in this block wins,
            // which gives done/done_sticky their pulse-default and set-over-clear priority.
            done <= 1'b0;
            if (ctrl_wr) done_sticky <= 1'b0;

            if (reg_wr_ok) begin
                case (cpu_addr)
                    REG_SRC_LO: src[7:0]  <= cpu_din;
                    REG_SRC_HI: src[15:8] <= cpu_din;
                    REG_CTRL: begin
                        clear_mode  <= cpu_din[1];
                        vblank_only <= cpu_din[2];
                    end
                    default:    count     <= cpu_din[4:0];
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (ctrl_wr && cpu_din[0]) begin
                        state <= S_WAIT_VB;
                        busy  <= 1'b1;
                        index <= '0;
                    end
                end
                S_WAIT_VB: begin
                    // Gate is re-evaluated before every byte so a transfer can straddle frames.
                    if (!vblank_only || vblank) begin
                        if (clear_mode) begin
                            state                 <= S_WRITE;
                            bus.spriteram_wr      <= 1'b1;
                            bus.spriteram_addr    <= index;
                            bus.spriteram_data_in <= 8'h00;
                        end else begin
                            state        <= S_REQ;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= src + 16'(index);
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_ack) begin
                        state                 <= S_WRITE;
                        bus.mem_req           <= 1'b0;
                        bus.spriteram_wr      <= 1'b1;
                        bus.spriteram_addr    <= index;
                        bus.spriteram_data_in <= bus.mem_data;
                    end
                end
                S_WRITE: begin
                    bus.spriteram_wr <= 1'b0;
                    index            <= index + 1'b1;
                    if (index == last_index) begin
                        state <= S_FINISH;
                        done  <= 1'b1;
                    end else begin
                        state <= S_WAIT_VB;
                    end
                end
                S_FINISH: begin
                    state       <= S_IDLE;
                    busy        <= 1'b0;
                    done_sticky <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
